user_udp2uart: RTL and testbench

//  Ethernet-to-UART return path: counterpart of the UART-to-UDP bridge.

---
 rtl/udp2uart_pkg.sv | 24 ++
 rtl/user_udp2uart_if.sv | 23 ++
 rtl/udp2uart_fifo.sv | 77 +++++++
 rtl/user_udp2uart.sv | 147 ++++++++++++++
 tb/tb_user_udp2uart.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/udp2uart_pkg.sv
// Shared types and constants for the UDP-to-UART return path.
package udp2uart_pkg;

  localparam int ENTRY_W = 9;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_DEC     = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } tx_state_e;

  // FIFO entry: marker=1 flags an end-of-packet, data is then don't-care.
  typedef struct packed {
    logic       marker;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/user_udp2uart_if.sv
// Payload-in / UART-out signal bundle of the UDP-to-UART bridge.
interface user_udp2uart_if;

  logic        udp_rec_en;
  logic [7:0]  udp_rec_data;
  logic        udp_rec_pkt_done;
  logic        uart_tx_busy;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        fifo_full;
  logic [15:0] drop_cnt;

  modport master (
    output udp_rec_en, udp_rec_data, udp_rec_pkt_done, uart_tx_busy,
    input  uart_tx_en, uart_tx_data, fifo_full, drop_cnt
  );

  modport slave (
    input  udp_rec_en, udp_rec_data, udp_rec_pkt_done, uart_tx_busy,
    output uart_tx_en, uart_tx_data, fifo_full, drop_cnt
  );

endinterface

// File: rtl/udp2uart_fifo.sv
// Single-clock FIFO of 9-bit entries with registered read data and registered full flag.
module udp2uart_fifo
  import udp2uart_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en_i,
  input  entry_t wr_data_i,
  input  logic   rd_en_i,
  output entry_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  entry_t      mem_q [DEPTH];
  entry_t      dout_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        wr_ok_s, rd_ok_s, empty_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign wr_ok_s = wr_en_i & ~full_q;
  assign rd_ok_s = rd_en_i & ~empty_s;

  // Pointer advance and full flag for the next cycle (extra MSB tells full from empty)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
             (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointers, flag and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      if (rd_ok_s) begin
        dout_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign rd_data_o = dout_q;
  assign full_o    = full_q;
  assign empty_o   = empty_s;

endmodule

// File: rtl/user_udp2uart.sv
// UDP payload to UART bridge: write arbiter with pending end-of-packet marker,
// overflow drop counter, and the FSM that feeds uart_tx one byte at a time.
module user_udp2uart
  import udp2uart_pkg::*;
#(
  parameter int FIFO_AW     = 9,
  parameter bit APPEND_CRLF = 1'b1,
  parameter int ACK_TMO     = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  user_udp2uart_if.slave u2u_if
);

  localparam int            TW      = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);
  localparam logic [TW-1:0] TMO_VAL = TW'(ACK_TMO);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  entry_t        wr_data_s, rd_data_s;
  logic          wr_en_s, rd_en_s, fifo_full_s, fifo_empty_s;
  logic          pend_mk_q, pend_mk_d;
  logic [15:0]   drop_q, drop_d;
  tx_state_e     state_q, state_d;
  logic          crlf_q, crlf_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;

  udp2uart_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en_s),
    .wr_data_i(wr_data_s),
    .rd_en_i  (rd_en_s),
    .rd_data_o(rd_data_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s)
  );

  // Write arbiter: bytes win the port; a marker waits in pend_mk until a free, non-full cycle
  always_comb begin
    wr_en_s          = 1'b0;
    wr_data_s.marker = 1'b0;
    wr_data_s.data   = 8'h00;
    pend_mk_d        = pend_mk_q;
    drop_d           = drop_q;
    if (u2u_if.udp_rec_en) begin
      wr_en_s        = 1'b1;
      wr_data_s.data = u2u_if.udp_rec_data;
      pend_mk_d      = pend_mk_q | u2u_if.udp_rec_pkt_done;
      if (fifo_full_s && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end else if (pend_mk_q || u2u_if.udp_rec_pkt_done) begin
      wr_en_s          = 1'b1;
      wr_data_s.marker = 1'b1;
      pend_mk_d        = fifo_full_s;
    end else begin
      pend_mk_d = 1'b0;
    end
  end

  // TX FSM next state; CR/LF are synthesised here rather than stored in the FIFO
  always_comb begin
    state_d   = state_q;
    rd_en_s   = 1'b0;
    crlf_d    = crlf_q;
    tmr_d     = tmr_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          rd_en_s = 1'b1;
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: state_d = ST_DEC;
      ST_DEC: begin
        if (!rd_data_s.marker) begin
          tx_data_d = rd_data_s.data;
          state_d   = ST_SEND;
        end else if (APPEND_CRLF) begin
          tx_data_d = ASCII_CR;
          crlf_d    = 1'b1;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        tmr_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (u2u_if.uart_tx_busy || (tmr_q == TMO_VAL)) begin
          state_d = ST_WAIT_LO;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (u2u_if.uart_tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (crlf_q) begin
          crlf_d    = 1'b0;
          tx_data_d = ASCII_LF;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_en_d = (state_d == ST_SEND);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_mk_q <= 1'b0;
      drop_q    <= 16'h0000;
      crlf_q    <= 1'b0;
      tmr_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pend_mk_q <= pend_mk_d;
      drop_q    <= drop_d;
      crlf_q    <= crlf_d;
      tmr_q     <= tmr_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign u2u_if.uart_tx_en   = tx_en_q;
  assign u2u_if.uart_tx_data = tx_data_q;
  assign u2u_if.fifo_full    = fifo_full_s;
  assign u2u_if.drop_cnt     = drop_q;

endmodule

// File: tb/tb_user_udp2uart.sv
// Directed bench for user_udp2uart: two instances (CR/LF on and off), a uart_tx busy model per instance.
module tb_user_udp2uart;

  localparam int AW       = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int BUSY_LEN = 20;
  localparam int TMO      = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  user_udp2uart_if ifa ();
  user_udp2uart_if ifb ();

  user_udp2uart #(.FIFO_AW(AW), .APPEND_CRLF(1'b1), .ACK_TMO(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .u2u_if(ifa)
  );
  user_udp2uart #(.FIFO_AW(AW), .APPEND_CRLF(1'b0), .ACK_TMO(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .u2u_if(ifb)
  );

  logic [7:0] qa_d[$];
  logic [7:0] qb_d[$];
  int         qa_c[$];
  int         bcnt_a = 0;
  int         bcnt_b = 0;
  logic       stall_a = 1'b0;
  logic       mute_a  = 1'b0;

  // Pulse recorder and busy model for instance A
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt_a = 0;
    end else if (ifa.uart_tx_en) begin
      qa_d.push_back(ifa.uart_tx_data);
      qa_c.push_back(cyc);
      if (!mute_a) bcnt_a = BUSY_LEN;
    end else if (bcnt_a > 0) begin
      bcnt_a = bcnt_a - 1;
    end
    ifa.uart_tx_busy = stall_a || (bcnt_a > 0);
  end

  // Pulse recorder and busy model for instance B
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt_b = 0;
    end else if (ifb.uart_tx_en) begin
      qb_d.push_back(ifb.uart_tx_data);
      bcnt_b = BUSY_LEN;
    end else if (bcnt_b > 0) begin
      bcnt_b = bcnt_b - 1;
    end
    ifb.uart_tx_busy = (bcnt_b > 0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One input cycle on instance A (sel=0) or B (sel=1)
  task automatic put(input bit sel, input logic [7:0] d, input logic en, input logic done);
    @(negedge clk);
    if (sel) begin
      ifb.udp_rec_en = en; ifb.udp_rec_data = d; ifb.udp_rec_pkt_done = done;
    end else begin
      ifa.udp_rec_en = en; ifa.udp_rec_data = d; ifa.udp_rec_pkt_done = done;
    end
    @(negedge clk);
    ifa.udp_rec_en = 1'b0; ifa.udp_rec_pkt_done = 1'b0;
    ifb.udp_rec_en = 1'b0; ifb.udp_rec_pkt_done = 1'b0;
  endtask

  task automatic wait_pulses(input bit sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? qb_d.size() : qa_d.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  logic [7:0] exp1 [4] = '{8'h41, 8'h42, 8'h0D, 8'h0A};
  logic [7:0] exp3 [3] = '{8'h55, 8'h0D, 8'h0A};
  int t0;

  initial begin
    ifa.udp_rec_en = 1'b0; ifa.udp_rec_data = 8'h00; ifa.udp_rec_pkt_done = 1'b0;
    ifb.udp_rec_en = 1'b0; ifb.udp_rec_data = 8'h00; ifb.udp_rec_pkt_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tx_en",   32'(ifa.uart_tx_en),   32'h0);
    check_eq("rst_tx_data", 32'(ifa.uart_tx_data), 32'h0);
    check_eq("rst_full",    32'(ifa.fifo_full),    32'h0);
    check_eq("rst_drop",    32'(ifa.drop_cnt),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 41,42 then marker with CR/LF, first pulse three edges after the write edge
    t0 = cyc;
    ifa.udp_rec_en = 1'b1; ifa.udp_rec_data = 8'h41;
    @(negedge clk); ifa.udp_rec_data = 8'h42;
    @(negedge clk); ifa.udp_rec_en = 1'b0; ifa.udp_rec_pkt_done = 1'b1;
    @(negedge clk); ifa.udp_rec_pkt_done = 1'b0;
    wait_pulses(1'b0, 4, 400);
    check_eq("t1_count", 32'(qa_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("t1_data", 32'(qa_d[i]), 32'(exp1[i]));
    check_eq("t1_latency", 32'(qa_c[0]), 32'(t0 + 1 + 3));
    repeat (60) @(negedge clk);
    check_eq("t1_no_extra", 32'(qa_d.size()), 32'd4);

    // 2: same packet without CR/LF
    put(1'b1, 8'h41, 1'b1, 1'b0);
    put(1'b1, 8'h42, 1'b1, 1'b0);
    put(1'b1, 8'h00, 1'b0, 1'b1);
    wait_pulses(1'b1, 2, 300);
    repeat (60) @(negedge clk);
    check_eq("t2_count", 32'(qb_d.size()), 32'd2);
    check_eq("t2_data0", 32'(qb_d[0]), 32'h41);
    check_eq("t2_data1", 32'(qb_d[1]), 32'h42);

    // 3: byte and pkt_done in the same cycle
    qa_d.delete(); qa_c.delete();
    put(1'b0, 8'h55, 1'b1, 1'b1);
    wait_pulses(1'b0, 3, 300);
    repeat (80) @(negedge clk);
    check_eq("t3_count", 32'(qa_d.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("t3_data", 32'(qa_d[i]), 32'(exp3[i]));

    // 4: FSM held in WAIT_LO, DEPTH+3 bytes written back-to-back
    qa_d.delete(); qa_c.delete();
    put(1'b0, 8'hEE, 1'b1, 1'b0);
    wait_pulses(1'b0, 1, 50);
    stall_a = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      ifa.udp_rec_en = 1'b1; ifa.udp_rec_data = 8'(8'h60 + i);
    end
    @(negedge clk); ifa.udp_rec_en = 1'b0;
    @(negedge clk);
    check_eq("t4_full", 32'(ifa.fifo_full), 32'h1);
    check_eq("t4_drop", 32'(ifa.drop_cnt), 32'd3);
    stall_a = 1'b0;
    wait_pulses(1'b0, DEPTH + 1, 1500);
    repeat (40) @(negedge clk);
    check_eq("t4_count", 32'(qa_d.size()), 32'(DEPTH + 1));
    check_eq("t4_first", 32'(qa_d[0]), 32'hEE);
    for (int i = 0; i < DEPTH; i++) check_eq("t4_order", 32'(qa_d[i + 1]), 32'(8'h60 + i));
    check_eq("t4_unfull", 32'(ifa.fifo_full), 32'h0);

    // 5: busy never rises, the ack timeout must release the FSM
    qa_d.delete(); qa_c.delete();
    mute_a = 1'b1;
    put(1'b0, 8'h77, 1'b1, 1'b0);
    put(1'b0, 8'h78, 1'b1, 1'b0);
    wait_pulses(1'b0, 2, 200);
    check_eq("t5_count", 32'(qa_d.size()), 32'd2);
    check_eq("t5_data1", 32'(qa_d[1]), 32'h78);
    check_eq("t5_gap", 32'(qa_c[1] - qa_c[0]), 32'(TMO + 6));
    repeat (40) @(negedge clk);
    mute_a = 1'b0;

    // 6: one-cycle reset in the middle of a frame
    qa_d.delete(); qa_c.delete();
    put(1'b0, 8'h11, 1'b1, 1'b0);
    put(1'b0, 8'h12, 1'b1, 1'b0);
    put(1'b0, 8'h13, 1'b1, 1'b0);
    wait_pulses(1'b0, 1, 50);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_tx_en",   32'(ifa.uart_tx_en),   32'h0);
    check_eq("t6_tx_data", 32'(ifa.uart_tx_data), 32'h0);
    check_eq("t6_full",    32'(ifa.fifo_full),    32'h0);
    check_eq("t6_drop",    32'(ifa.drop_cnt),     32'h0);
    qa_d.delete(); qa_c.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("t6_silent", 32'(qa_d.size()), 32'd0);
    put(1'b0, 8'h21, 1'b1, 1'b0);
    wait_pulses(1'b0, 1, 50);
    repeat (40) @(negedge clk);
    check_eq("t6_count", 32'(qa_d.size()), 32'd1);
    check_eq("t6_data",  32'(qa_d[0]), 32'h21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
